// File: rtl/sipo_frame_receiver_if.sv
// Bit-strobe / serial-line / parallel-word bundle for sipo_frame_receiver.
//   en        : bit strobe, din is only looked at when high
//   din       : registered serial line, idles at 1
//   data      : last correctly framed word
//   valid     : one-cycle pulse when data has just been updated
//   frame_err : one-cycle pulse when the stop bit was sampled low
//   busy      : high while a frame is being received
// master = the side feeding bits in, slave = the receiver.
interface sipo_frame_receiver_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             din;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output en, din,
        input  data, valid, frame_err, busy
    );

    modport slave (
        input  en, din,
        output data, valid, frame_err, busy
    );
endinterface

// File: rtl/sipo_frame_receiver.sv
// Serial-in, parallel-out frame receiver: start bit (0), WIDTH data bits
// LSB-first, stop bit (1). A good frame updates data and pulses valid for one
// cycle. A bad stop bit pulses frame_err and leaves data unchanged.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset, wins over en
//   bus : sipo_frame_receiver_if.slave (en, din in; data, valid, frame_err, busy out)
//
// state | meaning
// IDLE  | waiting for a start bit (din=0 on an enabled edge)
// SHIFT | shifting in WIDTH data bits, LSB first
// STOP  | next enabled bit is the stop bit
module sipo_frame_receiver #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    sipo_frame_receiver_if.slave  bus
);
    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STOP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (!bus.din) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    // New bit enters at the MSB so the first data bit lands in bit 0.
                    shreg_d = {bus.din, shreg_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // A low stop bit is swallowed here, never reused as a start bit.
                    if (bus.din) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state_q == SHIFT) || (state_q == STOP);
endmodule

// File: tb/tb_sipo_frame_receiver.sv
module tb_sipo_frame_receiver;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   edge_cnt;
    int   total;
    int   bad;

    sipo_frame_receiver_if #(.WIDTH(W)) bus ();

    sipo_frame_receiver #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] data;
        bit           err;
        int           due;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        logic [W-1:0] word;
        bit           stop;
        bit           gaps;
        bit           b2b;
        logic [W-1:0] exp_data;
        bit           exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every valid / frame_err pulse must match the oldest
    // pending expectation, including the edge it was due on.
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst && (bus.valid || bus.frame_err)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, bus.valid, bus.frame_err}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_valid", bus.valid, !e.err);
                    chk("pulse_frame_err", bus.frame_err, e.err);
                    chk("pulse_data", bus.data, e.data);
                    chk("pulse_edge", edge_cnt, e.due);
                end
            end
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        chk("busy_idle", bus.busy, 1'b0);
        bus.en  = 1'b1;
        bus.din = 1'b1;
    endtask

    task automatic send_frame(input logic [W-1:0] word, input bit stop, input bit gaps,
                              input logic [W-1:0] exp_data, input bit exp_err, input int exp_lat);
        sb_t  e;
        logic b;
        @(negedge clk);
        chk("busy_before_start", bus.busy, 1'b0);
        bus.en  = 1'b1;
        bus.din = 1'b0;
        e.data = exp_data;
        e.err  = exp_err;
        e.due  = edge_cnt + 1 + exp_lat;
        sb_q.push_back(e);
        for (int i = 0; i <= W; i++) begin
            b = (i < W) ? word[i] : stop;
            if (gaps) begin
                @(negedge clk);
                chk("busy_gap", bus.busy, 1'b1);
                bus.en  = 1'b0;
                bus.din = ~b;
            end
            @(negedge clk);
            chk("busy_frame", bus.busy, 1'b1);
            bus.en  = 1'b1;
            bus.din = b;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{word: 8'hA5, stop: 1'b1, gaps: 1'b0, b2b: 1'b0, exp_data: 8'hA5, exp_err: 1'b0, exp_lat: 9};
        vecs[1] = '{word: 8'h3C, stop: 1'b1, gaps: 1'b0, b2b: 1'b0, exp_data: 8'h3C, exp_err: 1'b0, exp_lat: 9};
        vecs[2] = '{word: 8'hC3, stop: 1'b1, gaps: 1'b0, b2b: 1'b1, exp_data: 8'hC3, exp_err: 1'b0, exp_lat: 9};
        vecs[3] = '{word: 8'h5A, stop: 1'b1, gaps: 1'b1, b2b: 1'b0, exp_data: 8'h5A, exp_err: 1'b0, exp_lat: 18};
        vecs[4] = '{word: 8'hFF, stop: 1'b0, gaps: 1'b0, b2b: 1'b0, exp_data: 8'h5A, exp_err: 1'b1, exp_lat: 9};

        // Reset held for two edges with a would-be start bit on the line.
        rst     = 1'b1;
        bus.en  = 1'b1;
        bus.din = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_data", bus.data, 8'h00);
            chk("rst_valid", bus.valid, 1'b0);
            chk("rst_frame_err", bus.frame_err, 1'b0);
            chk("rst_busy", bus.busy, 1'b0);
        end
        rst     = 1'b0;
        bus.din = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_data", bus.data, 8'h00);
            chk("post_rst_busy", bus.busy, 1'b0);
            chk("post_rst_valid", bus.valid, 1'b0);
        end

        for (int v = 0; v < 5; v++) begin
            if (!vecs[v].b2b) idle_cycle();
            send_frame(vecs[v].word, vecs[v].stop, vecs[v].gaps,
                       vecs[v].exp_data, vecs[v].exp_err, vecs[v].exp_lat);
        end

        // Idle line after the bad stop bit: nothing may start.
        for (int i = 0; i < 12; i++) idle_cycle();
        chk("data_after_err", bus.data, 8'h5A);

        // Reset after four data bits of a frame.
        @(negedge clk);
        chk("busy_before_abort", bus.busy, 1'b0);
        bus.en  = 1'b1;
        bus.din = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.din = i[0];
        end
        @(negedge clk);
        chk("busy_mid_frame", bus.busy, 1'b1);
        rst     = 1'b1;
        bus.din = 1'b0;
        @(negedge clk);
        chk("abort_data", bus.data, 8'h00);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_valid", bus.valid, 1'b0);
        chk("abort_frame_err", bus.frame_err, 1'b0);
        rst     = 1'b0;
        bus.din = 1'b1;
        idle_cycle();
        send_frame(8'h81, 1'b1, 1'b0, 8'h81, 1'b0, 9);
        idle_cycle();

        for (int i = 0; i < 40 && sb_q.size() != 0; i++) idle_cycle();
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("final_data", bus.data, 8'h81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
